// File: rtl/seq_mult_param.sv
// Shift-add sequential multiplier for unsigned or two's-complement operands.
// Stops early once the remaining multiplier bits are zero; start/busy/done handshake.
module seq_mult_param #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ma_q, ma_d;
    logic [PW-1:0]    acc_q, acc_d, acc_next;
    logic [PW-1:0]    product_q, product_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             neg_q, neg_d;
    logic             accept;

    // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
        abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    assign accept = start && ((state_q == StIdle) || (state_q == StFinish));

    always_comb begin
        state_d   = state_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        acc_next  = acc_q + (mb_q[0] ? ma_q : '0);

        case (state_q)
            StIdle, StFinish: begin
                if (accept) begin
                    ma_d  = {{WIDTH{1'b0}}, abs_a};
                    mb_d  = abs_b;
                    acc_d = '0;
                    neg_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (abs_b == '0) begin
                        state_d   = StFinish;
                        product_d = '0;
                    end else begin
                        state_d = StRun;
                    end
                end else if (state_q == StFinish) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = acc_next;
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                if (mb_d == '0) begin
                    state_d   = StFinish;
                    product_d = neg_q ? -acc_next : acc_next;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StFinish);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: 4-bit and 8-bit instances checked against an
// integer reference model for product value and done timing.
module tb_seq_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] prod4;
    logic       rst8, start8, sm8, busy8, done8;
    logic [7:0] a8, b8;
    logic [15:0] prod8;

    seq_mult_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(rst4), .start(start4), .a(a4), .b(b4), .signed_mode(sm4),
        .busy(busy4), .done(done4), .product(prod4)
    );

    seq_mult_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(rst8), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic rst4_e, rst8_e;
    logic [7:0]  prev4;
    logic [15:0] prev8;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst4_e <= rst4;
        rst8_e <= rst8;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer multiply of the operand values, k = bit length of |b|.
    function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input bit sm, output logic [15:0] p, output int k);
        longint av, bv, pr, bm;
        av = longint'(a) & ((longint'(1) << w) - 1);
        bv = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && ((av >> (w - 1)) & 1) == 1) av = av - (longint'(1) << w);
        if (sm && ((bv >> (w - 1)) & 1) == 1) bv = bv - (longint'(1) << w);
        pr = av * bv;
        p  = 16'(pr & ((longint'(1) << (2 * w)) - 1));
        bm = (bv < 0) ? -bv : bv;
        k  = 0;
        while (bm != 0) begin
            k++;
            bm = bm >> 1;
        end
        assert (k <= w) else $error("run length %0d exceeds width %0d", k, w);
    endfunction

    always @(negedge clk) begin
        if (done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done4_unexpected: got done=1, expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("prod4", {24'b0, prod4}, {16'b0, e.prod});
                chk("done4_cycle", cyc, e.cyc);
            end
        end
        if (rst4_e === 1'b0 && done4 !== 1'b1) chk("prod4_hold", {24'b0, prod4}, {24'b0, prev4});
        prev4 = prod4;
    end

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done8_unexpected: got done=1, expected no done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("prod8", {16'b0, prod8}, {16'b0, e.prod});
                chk("done8_cycle", cyc, e.cyc);
            end
        end
        if (rst8_e === 1'b0 && done8 !== 1'b1) chk("prod8_hold", {16'b0, prod8}, {16'b0, prev8});
        prev8 = prod8;
    end

    // Call only when the DUT is in IDLE or FINISH, just after a falling edge.
    task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input bit sm);
        logic [15:0] p;
        int          k;
        exp_t        e;
        model(w, a, b, sm, p, k);
        if (w == 4) begin
            a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = 1'b1;
        end else begin
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        e.prod = p;
        e.cyc  = cyc + k;
        if (w == 4) begin
            q4.push_back(e);
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        end else begin
            q8.push_back(e);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        end
    endtask

    task automatic wait_done(input int w);
        int   n;
        logic d;
        n = 0;
        d = 1'b0;
        while (!d && n < 40) begin
            @(negedge clk);
            n++;
            d = (w == 4) ? (done4 === 1'b1) : (done8 === 1'b1);
        end
        if (!d) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: width %0d got no done, expected done within 40 cycles", w);
        end
    endtask

    initial begin
        logic [15:0] p;
        int          k;
        int          n;
        exp_t        e;

        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy4", {31'b0, busy4}, 32'd0);
        chk("rst_done4", {31'b0, done4}, 32'd0);
        chk("rst_prod4", {24'b0, prod4}, 32'd0);
        chk("rst_busy8", {31'b0, busy8}, 32'd0);
        chk("rst_prod8", {16'b0, prod8}, 32'd0);
        rst4 = 1'b0;
        rst8 = 1'b0;
        @(negedge clk);

        // 13*11 unsigned: busy for 5 cycles, done in the 5th
        issue(4, 8'd13, 8'd11, 1'b0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (busy4 !== 1'b1) break;
            n++;
            if (done4 === 1'b1) chk("prod4_13x11", {24'b0, prod4}, 32'h8F);
        end
        chk("busy4_len", n, 32'd5);

        issue(4, 8'b1101, 8'b0101, 1'b1);
        wait_done(4);
        chk("prod4_m3x5", {24'b0, prod4}, 32'hF1);
        @(negedge clk);
        issue(4, 8'b1000, 8'b1000, 1'b1);
        wait_done(4);
        chk("prod4_m8xm8", {24'b0, prod4}, 32'h40);
        @(negedge clk);
        issue(4, 8'd15, 8'd15, 1'b0);
        wait_done(4);
        chk("prod4_15x15", {24'b0, prod4}, 32'hE1);
        @(negedge clk);
        issue(4, 8'b1000, 8'b0001, 1'b1);
        wait_done(4);
        chk("prod4_m8x1", {24'b0, prod4}, 32'hF8);
        @(negedge clk);
        issue(4, 8'd9, 8'd0, 1'b0);
        wait_done(4);
        chk("prod4_9x0", {24'b0, prod4}, 32'h00);
        @(negedge clk);
        issue(4, 8'd0, 8'b1111, 1'b1);
        wait_done(4);
        chk("prod4_0xm1", {24'b0, prod4}, 32'h00);
        @(negedge clk);

        // Start pulsed mid-RUN is ignored: the monitor rejects any extra done
        issue(4, 8'd13, 8'd11, 1'b0);
        repeat (2) @(negedge clk);
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(4);
        repeat (6) @(negedge clk);
        chk("busy4_after_ignore", {31'b0, busy4}, 32'd0);

        // Start held through FINISH gives a back-to-back accept
        issue(4, 8'd13, 8'd11, 1'b0);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd3; b4 = 4'd5; sm4 = 1'b0;
        wait_done(4);
        chk("prod4_b2b_first", {24'b0, prod4}, 32'd143);
        model(4, 8'd3, 8'd5, 1'b0, p, k);
        @(posedge clk);
        #1;
        e.prod = p;
        e.cyc  = cyc + k;
        q4.push_back(e);
        start4 = 1'b0;
        wait_done(4);
        chk("prod4_b2b_second", {24'b0, prod4}, 32'd15);
        @(negedge clk);

        // Reset together with start: nothing accepted
        rst4 = 1'b1; start4 = 1'b1; a4 = 4'd5; b4 = 4'd5;
        @(posedge clk);
        #1;
        chk("busy4_rst_start", {31'b0, busy4}, 32'd0);
        @(negedge clk);
        rst4 = 1'b0; start4 = 1'b0;
        @(negedge clk);

        // Reset on the 3rd RUN cycle discards the operation
        issue(8, 8'd200, 8'd255, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        q8.delete();
        @(posedge clk);
        #1;
        chk("busy8_mid_rst", {31'b0, busy8}, 32'd0);
        chk("done8_mid_rst", {31'b0, done8}, 32'd0);
        chk("prod8_mid_rst", {16'b0, prod8}, 32'd0);
        @(negedge clk);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        issue(8, 8'd200, 8'd255, 1'b0);
        wait_done(8);
        chk("prod8_200x255", {16'b0, prod8}, 32'hC738);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            issue(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom));
            wait_done(4);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            issue(8, 8'($urandom), 8'($urandom), 1'($urandom));
            wait_done(8);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("q4_drained", q4.size(), 32'd0);
        chk("q8_drained", q8.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parameterised shift-add sequential multiplier: WIDTH-bit unsigned or two's-complement operands produce a 2·WIDTH-bit product. It uses a start/busy/done handshake and terminates early once the remaining multiplier bits are zero. It is the arithmetic engine for datapath blocks that need a multiply without a combinational array. It replaces fixed 4-bit, free-running multiplier datapaths with an explicit controller.

## Interface
- WIDTH, default 4: operand width in bits; legal values are 2..32.
- clk  input  1: single clock; all state changes on the rising edge.
- reset  input  1: synchronous, active-high; dominates all other inputs.
- start  input  1: request. It is sampled only in IDLE or FINISH.
- a  input  WIDTH: multiplicand, captured at accept.
- b  input  WIDTH: multiplier, captured at accept.
- signed_mode  input  1: 1 selects two's-complement operands and product; captured at accept.
- busy  output  1: high in RUN and FINISH.
- done  output  1: one-cycle pulse in FINISH; product is valid.
- product  output  2·WIDTH: result. It holds its value until the next FINISH or reset.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one partial-product step per cycle.
  - FINISH: one cycle; done=1.
- Accept: start=1 in IDLE or FINISH at a rising edge. At that edge:
  - ma ← |a| zero-extended to 2·WIDTH.
  - mb ← |b| (WIDTH bits).
  - acc ← 0.
  - neg ← signed_mode & (a[MSB] ^ b[MSB]).
- Magnitude rules:
  - In unsigned mode, |x| = x.
  - In signed mode, |x| = x[MSB] ? (~x + 1) : x, taken as unsigned WIDTH bits.
  - The most-negative value -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits.
- Next state after accept: FINISH directly if |b| == 0, else RUN.
- RUN, each cycle:
  - If mb[0], acc ← acc + ma. The sum is truncated to 2·WIDTH bits; it never overflows for legal operands.
  - ma ← ma << 1.
  - mb ← mb >> 1.
  - If the shifted mb == 0, go to FINISH and load product ← neg ? (−acc_next mod 2^(2·WIDTH)) : acc_next on the same edge.
- RUN length: k = index of the highest set bit of |b| plus 1, so 1 ≤ k ≤ WIDTH. A step counter is not required, but a bench assertion checks k ≤ WIDTH.
- FINISH:
  - done=1 and busy=1 for exactly one cycle.
  - If start=1, a new operation is accepted (back-to-back). Otherwise the next state is IDLE.
- For the |b| == 0 path, product ← 0 on the accept edge. Negative zero is never produced.
- start in RUN is ignored; it is neither queued nor an error.
- a, b and signed_mode are don't-care outside the accept edge.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, internal registers 0.
- Reset asserted mid-RUN or in FINISH: the next edge forces all reset values. The operation is discarded with no done pulse.
- Latency, counted from the accept edge to the edge entering FINISH:
  - max(k,0) edges if |b| ≠ 0.
  - 0 extra edges if |b| == 0; FINISH is the cycle right after accept.
  - done is therefore high during cycle k+1 after accept; the worst case is WIDTH+1 cycles.
- Throughput: back-to-back accepts from FINISH give one result per k+1 cycles.
- busy rises the cycle after accept and falls the cycle after the last FINISH with no new accept.
- product changes only on the edge entering FINISH, or on reset. It is stable while busy in RUN, so it still shows the previous result.
- Simultaneous reset and start: reset wins; nothing is accepted.

## Test plan
- Unsigned, WIDTH=4: a=13, b=11, signed_mode=0, start one cycle.
  - Required: k=4, done is high in the 5th cycle after accept, product=8'h8F (143), busy was high for 5 cycles.
- Signed, WIDTH=4: a=4'b1101 (−3), b=4'b0101 (5), signed_mode=1.
  - Required: k=3, done in the 4th cycle, product=8'hF1 (−15).
- Corner magnitudes, WIDTH=4:
  - Signed a=b=4'b1000 (−8·−8) → product=8'h40, k=4.
  - Unsigned 15·15 → 8'hE1.
  - Signed a=4'b1000, b=4'b0001 → 8'hF8, k=1, done in the 2nd cycle.
- Zero and early termination, WIDTH=4:
  - b=0, a=9 → done in the 1st cycle after accept, product=0.
  - Signed a=0, b=−1 → product=0, not 8'h00-negated garbage.
- Handshake, WIDTH=4:
  - Pulse start again mid-RUN → ignored; exactly one done.
  - Hold start high through FINISH with new operands 3·5 → second accept, done pulses twice, products 143 then 15.
- Reset mid-operation, WIDTH=8:
  - Accept 200·255 (unsigned), assert reset on the 3rd RUN cycle → next cycle busy=0, done=0, product=0, and no done afterwards.
  - A following 200·255 gives 16'hC738 after 9 cycles.
